// File: rtl/mul_sequencer.sv
// Sequential shift-and-add multiplier sequencer.
// It iterates a WORD-bit multiply one multiplier bit per cycle and stalls the
// pipeline while running. In its single DONE cycle it steers the ALU wrapper
// to pass the product through (accumulator + zero) so flags can be updated.

package mul_sequencer_pkg;
  // ALU input source encodings shared with decode and the ALU wrapper.
  localparam logic [1:0] FROM_REGISTER    = 2'd0;
  localparam logic [1:0] FROM_IMMEDIATE   = 2'd1;
  localparam logic [1:0] FROM_ACCUMULATOR = 2'd2;
  localparam logic [1:0] FROM_ZERO        = 2'd3;
endpackage

module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WORD       = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            set_flags_i,
  input  logic            flush_i,
  input  logic [WORD-1:0] multiplicand_i,
  input  logic [WORD-1:0] multiplier_i,
  input  logic [1:0]      alu_input_1_select_i,
  input  logic [1:0]      alu_input_2_select_i,
  input  logic            update_flag_i,
  output logic [1:0]      alu_input_1_select_o,
  output logic [1:0]      alu_input_2_select_o,
  output logic            update_flag_o,
  output logic [WORD-1:0] accumulator_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CW = (WORD > 2) ? $clog2(WORD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [WORD-1:0] mcand_r, mcand_s;
  logic [WORD-1:0] mplier_r, mplier_s;
  logic [WORD-1:0] acc_r, acc_s;
  logic [CW-1:0]   count_r, count_s;
  logic            flags_pending_r, flags_pending_s;
  logic            accept_s;
  logic            last_iter_s;

  // A start only counts when idle and not being flushed in the same cycle.
  assign accept_s = (state_r == ST_IDLE) && start_i && !flush_i;

  // The current iteration is the last one when all WORD bits are consumed,
  // or, with early termination, when no set multiplier bits remain after the shift.
  assign last_iter_s = (count_r == CW'(WORD - 1)) ||
                       (EARLY_TERM && (mplier_r[WORD-1:1] == {(WORD-1){1'b0}}));

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r         <= ST_IDLE;
      mcand_r         <= {WORD{1'b0}};
      mplier_r        <= {WORD{1'b0}};
      acc_r           <= {WORD{1'b0}};
      count_r         <= {CW{1'b0}};
      flags_pending_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      mcand_r         <= mcand_s;
      mplier_r        <= mplier_s;
      acc_r           <= acc_s;
      count_r         <= count_s;
      flags_pending_r <= flags_pending_s;
    end
  end

  // Next-state and iteration logic; a flush returns to IDLE and freezes the datapath.
  always_comb begin
    state_s         = state_r;
    mcand_s         = mcand_r;
    mplier_s        = mplier_r;
    acc_s           = acc_r;
    count_s         = count_r;
    flags_pending_s = flags_pending_r;
    if (flush_i) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mcand_s         = multiplicand_i;
            mplier_s        = multiplier_i;
            acc_s           = {WORD{1'b0}};
            count_s         = {CW{1'b0}};
            flags_pending_s = set_flags_i;
            if (EARLY_TERM && (multiplier_i == {WORD{1'b0}})) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (mplier_r[0]) begin
            acc_s = acc_r + mcand_r;
          end else begin
            acc_s = acc_r;
          end
          mcand_s  = {mcand_r[WORD-2:0], 1'b0};
          mplier_s = {1'b0, mplier_r[WORD-1:1]};
          count_s  = count_r + CW'(1);
          if (last_iter_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // ALU steering: pass decode through except in DONE, where the product is presented.
  always_comb begin
    alu_input_1_select_o = alu_input_1_select_i;
    alu_input_2_select_o = alu_input_2_select_i;
    update_flag_o        = update_flag_i;
    done_o               = 1'b0;
    if (state_r == ST_DONE) begin
      alu_input_1_select_o = FROM_ACCUMULATOR;
      alu_input_2_select_o = FROM_ZERO;
      update_flag_o        = flags_pending_r && !flush_i;
      done_o               = !flush_i;
    end else begin
      done_o = 1'b0;
    end
  end

  // Stall upstream from the accepting cycle through the last RUN cycle.
  assign stall_o       = accept_s || (state_r == ST_RUN);
  assign busy_o        = (state_r == ST_RUN);
  assign accumulator_o = acc_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: one instance per EARLY_TERM setting sharing the
// same stimulus, a cycle-level arithmetic model, directed scenarios and random traffic.

module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, set_flags, flush, upd_i;
  logic [31:0] a_i, b_i;
  logic [1:0]  sel1_i, sel2_i;

  logic [1:0]  sel1_o [2];
  logic [1:0]  sel2_o [2];
  logic        upd_o  [2];
  logic [31:0] acc_o  [2];
  logic        stall_o[2];
  logic        busy_o [2];
  logic        done_o [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // index 0: EARLY_TERM=1, index 1: EARLY_TERM=0
  mul_sequencer #(.WORD(32), .EARLY_TERM(1'b1)) dut_et1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .set_flags_i(set_flags),
    .flush_i(flush), .multiplicand_i(a_i), .multiplier_i(b_i),
    .alu_input_1_select_i(sel1_i), .alu_input_2_select_i(sel2_i),
    .update_flag_i(upd_i), .alu_input_1_select_o(sel1_o[0]),
    .alu_input_2_select_o(sel2_o[0]), .update_flag_o(upd_o[0]),
    .accumulator_o(acc_o[0]), .stall_o(stall_o[0]), .busy_o(busy_o[0]),
    .done_o(done_o[0]));

  mul_sequencer #(.WORD(32), .EARLY_TERM(1'b0)) dut_et0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .set_flags_i(set_flags),
    .flush_i(flush), .multiplicand_i(a_i), .multiplier_i(b_i),
    .alu_input_1_select_i(sel1_i), .alu_input_2_select_i(sel2_i),
    .update_flag_i(upd_i), .alu_input_1_select_o(sel1_o[1]),
    .alu_input_2_select_o(sel2_o[1]), .update_flag_o(upd_o[1]),
    .accumulator_o(acc_o[1]), .stall_o(stall_o[1]), .busy_o(busy_o[1]),
    .done_o(done_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Low 32 bits of a times the low k bits of b: the accumulator after k iterations.
  function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] mask;
    logic [63:0] p;
    mask = (k >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << k) - 64'd1);
    p = {32'd0, a} * ({32'd0, b} & mask);
    return p[31:0];
  endfunction

  // Number of RUN cycles an operation takes.
  function automatic int run_len(input logic [31:0] b, input bit et);
    if (!et) return 32;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 0;
  endfunction

  // Model state: remaining RUN cycles, pending DONE cycle, operands, iterations done.
  int          m_runs [2];
  bit          m_done [2];
  bit          m_flags[2];
  int          m_k    [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_acc  [2];

  // Model advance on each clock edge, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_runs[d] <= 0; m_done[d] <= 1'b0; m_flags[d] <= 1'b0;
        m_k[d] <= 0; m_a[d] <= 32'd0; m_b[d] <= 32'd0; m_acc[d] <= 32'd0;
      end else if (flush) begin
        m_runs[d] <= 0; m_done[d] <= 1'b0;
      end else if (m_done[d]) begin
        m_done[d] <= 1'b0;
      end else if (m_runs[d] > 0) begin
        m_k[d]    <= m_k[d] + 1;
        m_acc[d]  <= partial(m_a[d], m_b[d], m_k[d] + 1);
        m_runs[d] <= m_runs[d] - 1;
        m_done[d] <= (m_runs[d] == 1);
      end else if (start) begin
        m_a[d] <= a_i; m_b[d] <= b_i; m_flags[d] <= set_flags;
        m_k[d] <= 0; m_acc[d] <= 32'd0;
        m_runs[d] <= run_len(b_i, d == 0);
        m_done[d] <= (run_len(b_i, d == 0) == 0);
      end else begin
        m_runs[d] <= m_runs[d];
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit busy_e, idle_e;
      busy_e = (m_runs[d] > 0);
      idle_e = !busy_e && !m_done[d];
      chk($sformatf("busy[%0d]", d), {31'd0, busy_o[d]}, {31'd0, busy_e});
      chk($sformatf("done[%0d]", d), {31'd0, done_o[d]}, {31'd0, m_done[d] && !flush});
      chk($sformatf("stall[%0d]", d), {31'd0, stall_o[d]},
          {31'd0, busy_e || (idle_e && start && !flush)});
      chk($sformatf("acc[%0d]", d), acc_o[d], m_acc[d]);
      chk($sformatf("sel1[%0d]", d), {30'd0, sel1_o[d]},
          {30'd0, m_done[d] ? FROM_ACCUMULATOR : sel1_i});
      chk($sformatf("sel2[%0d]", d), {30'd0, sel2_o[d]},
          {30'd0, m_done[d] ? FROM_ZERO : sel2_i});
      chk($sformatf("updflag[%0d]", d), {31'd0, upd_o[d]},
          {31'd0, m_done[d] ? (m_flags[d] && !flush) : upd_i});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy_o[0] || busy_o[1] || done_o[0] || done_o[1]) && c < 60) begin
      tick();
      c++;
    end
    if (c >= 60) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; set_flags = 1'b0; flush = 1'b0; upd_i = 1'b0;
    a_i = 32'd0; b_i = 32'd0; sel1_i = FROM_REGISTER; sel2_i = FROM_IMMEDIATE;
    tick(); tick();
    #1;
    chk("rst_acc", acc_o[0], 32'd0);
    chk("rst_busy", {31'd0, busy_o[1]}, 32'd0);
    chk("rst_done", {31'd0, done_o[0]}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 7*6 with early termination: 3 RUN cycles, DONE in cycle 4.
    wait_idle();
    start = 1'b1; a_i = 32'd7; b_i = 32'd6;
    tick(); start = 1'b0; #1;
    c = 1;
    while (!done_o[0] && c < 40) begin tick(); #1; c++; end
    chk("s1_done_cycle", c, 32'd4);
    chk("s1_acc", acc_o[0], 32'd42);
    chk("s1_sel1", {30'd0, sel1_o[0]}, {30'd0, FROM_ACCUMULATOR});
    chk("s1_sel2", {30'd0, sel2_o[0]}, {30'd0, FROM_ZERO});

    // All-ones squared, full 32 iterations, flags requested.
    wait_idle();
    start = 1'b1; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; set_flags = 1'b1; upd_i = 1'b0;
    tick(); start = 1'b0; set_flags = 1'b0; #1;
    c = 1;
    while (!done_o[1] && c < 60) begin tick(); #1; c++; end
    chk("s2_done_cycle", c, 32'd33);
    chk("s2_acc", acc_o[1], 32'h0000_0001);
    chk("s2_updflag", {31'd0, upd_o[1]}, 32'd1);

    // Zero multiplier: straight to DONE.
    wait_idle();
    start = 1'b1; a_i = 32'h1234; b_i = 32'd0; #1;
    chk("s3_stall_accept", {31'd0, stall_o[0]}, 32'd1);
    tick(); start = 1'b0; #1;
    chk("s3_done", {31'd0, done_o[0]}, 32'd1);
    chk("s3_stall_done", {31'd0, stall_o[0]}, 32'd0);
    chk("s3_acc", acc_o[0], 32'd0);

    // Restart during RUN is ignored.
    wait_idle();
    start = 1'b1; a_i = 32'h0001_0000; b_i = 32'h0001_0000;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; a_i = 32'd5; b_i = 32'd3;
    tick(); start = 1'b0; #1;
    c = 4;
    while (!done_o[0] && c < 40) begin tick(); #1; c++; end
    chk("s4_done_cycle", c, 32'd18);
    chk("s4_acc", acc_o[0], 32'd0);

    // Flush in RUN cycle 5.
    wait_idle();
    start = 1'b1; a_i = 32'd3; b_i = 32'hFFFF_FFFF; set_flags = 1'b1;
    tick(); start = 1'b0; set_flags = 1'b0;
    tick(); tick(); tick(); tick();
    flush = 1'b1; upd_i = 1'b1;
    tick(); flush = 1'b0; #1;
    chk("s5_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("s5_done", {31'd0, done_o[0]}, 32'd0);
    chk("s5_stall", {31'd0, stall_o[0]}, 32'd0);
    chk("s5_updflag", {31'd0, upd_o[0]}, 32'd1);
    chk("s5_acc", acc_o[0], 32'd45);
    upd_i = 1'b0;

    // Reset in the middle of RUN.
    wait_idle();
    start = 1'b1; a_i = 32'd9; b_i = 32'hFFFF_FFFF;
    tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("s6_acc", acc_o[0], 32'd0);
    chk("s6_busy", {31'd0, busy_o[1]}, 32'd0);
    chk("s6_done", {31'd0, done_o[0]}, 32'd0);
    tick(); rst_n = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      set_flags = $urandom_range(0, 1);
      upd_i     = $urandom_range(0, 1);
      sel1_i    = 2'($urandom_range(0, 3));
      sel2_i    = 2'($urandom_range(0, 3));
      a_i       = $urandom;
      b_i       = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b_i = 32'd0;
      tick();
    end
    start = 1'b0; flush = 1'b0;
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter EARLY_TERM, default 1, meaning: 1 ends iteration as soon as all remaining multiplier bits are zero; 0 always runs WORD iterations.
REQ-002 The block SHALL have the following ports:
  - clk_i  in  1  sole clock; all state updates on its rising edge.
  - rst_n_i  in  1  asynchronous, active-low reset.
  - start_i  in  1  one-cycle multiply request from decode/execute.
  - set_flags_i  in  1  request is MULS; flags update on completion.
  - flush_i  in  1  pipeline flush; aborts any operation.
  - multiplicand_i  in  WORD  operand A, sampled on accepted start.
  - multiplier_i  in  WORD  operand B, sampled on accepted start.
  - alu_input_1_select_i  in  alu_input_source  decode's ALU port-1 select.
  - alu_input_2_select_i  in  alu_input_source  decode's ALU port-2 select.
  - update_flag_i  in  1  decode's flag-update request.
  - alu_input_1_select_o  out  alu_input_source  select driven to the ALU wrapper.
  - alu_input_2_select_o  out  alu_input_source  select driven to the ALU wrapper.
  - update_flag_o  out  1  flag-update enable to the ALU wrapper.
  - accumulator_o  out  WORD  product register; feeds the ALU wrapper accumulator input.
  - stall_o  out  1  holds upstream pipeline stages.
  - busy_o  out  1  high in RUN.
  - done_o  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, RUN, DONE.
REQ-004 A start SHALL be accepted only in IDLE with start_i=1 and flush_i=0; start_i in RUN or DONE SHALL be ignored.
REQ-005 On accept, the block SHALL load mcand=multiplicand_i, mplier=multiplier_i, acc=0, count=0, flags_pending=set_flags_i.
REQ-006 On accept, the next state SHALL be DONE if EARLY_TERM=1 and multiplier_i=0, otherwise RUN.
REQ-007 Each RUN cycle SHALL perform one iteration:
  - acc += mcand if mplier[0]=1 (modulo 2^WORD);
  - mcand <<= 1; mplier >>= 1; count++.
REQ-008 RUN SHALL exit to DONE after the iteration where count reaches WORD-1 (WORD iterations), or earlier when EARLY_TERM=1 and the shifted mplier is 0.
REQ-009 Latency SHALL be: accept in cycle 0, RUN in cycles 1..N, DONE in cycle N+1.
  - N=WORD with EARLY_TERM=0.
  - N=(index of the highest set bit of B)+1 with EARLY_TERM=1.
  - N=0 for B=0 with EARLY_TERM=1.
REQ-010 The result SHALL be the low WORD bits of A*B, identical for signed and unsigned operands; no overflow indication.
REQ-011 accumulator_o SHALL equal acc at all times and hold its value after DONE until the next accept.
REQ-012 In DONE, the block SHALL drive:
  - alu_input_1_select_o=FROM_ACCUMULATOR, alu_input_2_select_o=FROM_ZERO;
  - update_flag_o=flags_pending; done_o=1;
  - then go to IDLE.
REQ-013 Outside DONE, the select outputs and update_flag_o SHALL pass through the corresponding inputs unchanged.
REQ-014 stall_o SHALL be combinational: (IDLE & start_i & ~flush_i) | RUN; it SHALL be 0 in DONE so the multiply advances with its result.
REQ-015 busy_o SHALL be 1 exactly in RUN.
REQ-016 flush_i=1 in any state SHALL force IDLE on the next edge, with no done_o and update_flag_o following decode.
  - In DONE, flush_i=1 SHALL suppress done_o and force update_flag_o=0 in that cycle.
  - flush_i and start_i together SHALL give flush priority; no accept.
  - acc SHALL be left unchanged by a flush.
REQ-017 The block SHALL never assert update_flag_o from flags_pending except in the single DONE cycle.

Reset
REQ-018 rst_n_i=0 SHALL immediately force IDLE, acc=0, mcand=0, mplier=0, count=0 and flags_pending=0.
REQ-019 During and after reset, outputs SHALL be accumulator_o=0, stall_o=0 (unless start per REQ-014 after release), busy_o=0 and done_o=0, with the select outputs and update_flag_o in pass-through.
REQ-020 Reset asserted mid-RUN SHALL abort the operation with no done_o pulse.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
  - EARLY_TERM=1, A=7, B=6 -> 3 RUN cycles, done_o in cycle 4, accumulator_o=42, DONE selects FROM_ACCUMULATOR/FROM_ZERO.
  - EARLY_TERM=0, A=0xFFFFFFFF, B=0xFFFFFFFF, set_flags_i=1 -> 32 RUN cycles, accumulator_o=0x00000001, update_flag_o=1 only in DONE.
  - EARLY_TERM=1, B=0 -> IDLE->DONE in one cycle, accumulator_o=0, stall_o high only in the accept cycle.
  - start_i re-pulsed during RUN with different operands -> ignored; original product 0x10000*0x10000 gives accumulator_o=0.
  - flush_i in RUN cycle 5 -> IDLE next cycle, no done_o, update_flag_o follows update_flag_i, stall_o=0.
  - rst_n_i low mid-RUN -> asynchronous return to IDLE, accumulator_o=0, busy_o=0, no done_o.
